// File: rtl/c_sched_pkg.sv
// Shared types and constants for the C-tile drain scheduler.
// The watchdog feature of the scheduler is enabled with C_SCHED_WATCHDOG_EN.
package c_sched_pkg;

  localparam int NSETS   = 2;
  localparam int SHAPE_W = 16;

  typedef enum logic [1:0] {
    BS_FREE,
    BS_WRITING,
    BS_FULL,
    BS_DRAINING
  } bs_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_START,
    D_WAIT
  } drn_st_t;

  typedef struct packed {
    logic [SHAPE_W-1:0] rows;
    logic [SHAPE_W-1:0] cols;
  } tile_shape_t;

endpackage

// File: rtl/c_sched_order_q.sv
// Two-entry, one-bit FIFO holding bankset selects in commit order.
// Push and pop in the same cycle are both applied.
module c_sched_order_q
  import c_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_sel,
  input  logic pop,
  output logic head_sel,
  output logic empty,
  output logic full
);

  logic [NSETS-1:0] slot_q;
  logic [NSETS-1:0] slot_d;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             do_pop;
  logic             do_push;

  assign empty    = (cnt_q == 2'd0);
  assign full     = (cnt_q == 2'd2);
  assign head_sel = slot_q[0];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Pop shifts the tail into the head first, so a same-cycle push lands behind it.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (do_pop) begin
      slot_d[0] = slot_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (do_push) begin
      slot_d[cnt_d[0]] = push_sel;
      cnt_d            = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/c_tile_drain_scheduler.sv
// Arbitrates the two C-tile banksets between compute writeback and the drain engine.
// Define C_SCHED_WATCHDOG_EN to add the drain watchdog and err_timeout.
module c_tile_drain_scheduler
  import c_sched_pkg::*;
#(
  parameter int DIM_W       = 16,
  parameter int T           = 16,
  parameter int MAX_COLS    = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic             alloc_sel,
  input  logic             commit,
  input  logic             commit_sel,
  input  logic [DIM_W-1:0] commit_rows,
  input  logic [DIM_W-1:0] commit_cols,
  output logic             drn_start,
  output logic             drn_bankset_sel,
  output logic [DIM_W-1:0] drn_tile_rows,
  output logic [DIM_W-1:0] drn_tile_cols,
  input  logic             drn_done,
  output logic [1:0]       free_cnt,
  output logic             err_commit,
  output logic             err_shape,
  output logic             err_timeout
);

  localparam logic [DIM_W:0] ROWS_MAX = (DIM_W+1)'(T);
  localparam logic [DIM_W:0] COLS_MAX = (DIM_W+1)'(MAX_COLS);

  bs_state_t        bs_q   [NSETS];
  bs_state_t        bs_d   [NSETS];
  logic [DIM_W-1:0] rows_q [NSETS];
  logic [DIM_W-1:0] rows_d [NSETS];
  logic [DIM_W-1:0] cols_q [NSETS];
  logic [DIM_W-1:0] cols_d [NSETS];
  drn_st_t          drn_st_q;
  drn_st_t          drn_st_d;
  logic             last_gnt_q;
  logic             last_gnt_d;
  logic             alloc_gnt_d;
  logic             alloc_sel_d;
  logic             drn_sel_d;
  logic [DIM_W-1:0] drn_rows_d;
  logic [DIM_W-1:0] drn_cols_d;
  logic [1:0]       free_cnt_d;
  logic             err_commit_d;
  logic             err_shape_d;
  logic             pick;
  logic             shape_ok;
  logic             wd_fire;
  logic             q_push;
  logic             q_pop;
  logic             q_head;
  logic             q_empty;
  logic             q_full;

  c_sched_order_q u_order_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_sel (commit_sel),
    .pop      (q_pop),
    .head_sel (q_head),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign shape_ok = (commit_rows != '0) && (commit_cols != '0) &&
                    ({1'b0, commit_rows} <= ROWS_MAX) &&
                    ({1'b0, commit_cols} <= COLS_MAX);

  assign drn_start = (drn_st_q == D_START);

`ifdef C_SCHED_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_timeout_q;

  // Fires on the cycle whose increment would bring the count to TIMEOUT_CYC.
  assign wd_fire     = (drn_st_q == D_WAIT) && !drn_done && (wd_cnt == WD_LAST);
  assign err_timeout = err_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (drn_st_d == D_START)
        wd_cnt <= '0;
      else if (drn_st_q == D_WAIT)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire)
        err_timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Allocation, commit and drain each touch a bankset in a distinct source state,
  // so simultaneous events never collide on the same bankset.
  always_comb begin
    bs_d         = bs_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    drn_st_d     = drn_st_q;
    last_gnt_d   = last_gnt_q;
    alloc_gnt_d  = 1'b0;
    alloc_sel_d  = alloc_sel;
    drn_sel_d    = drn_bankset_sel;
    drn_rows_d   = drn_tile_rows;
    drn_cols_d   = drn_tile_cols;
    err_commit_d = err_commit;
    err_shape_d  = err_shape;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    pick         = 1'b0;
    free_cnt_d   = 2'd0;

    if (alloc_req && !alloc_gnt && (bs_q[0] == BS_FREE || bs_q[1] == BS_FREE)) begin
      if (bs_q[0] == BS_FREE && bs_q[1] == BS_FREE)
        pick = ~last_gnt_q;
      else
        pick = (bs_q[1] == BS_FREE);
      alloc_gnt_d = 1'b1;
      alloc_sel_d = pick;
      last_gnt_d  = pick;
      bs_d[pick]  = BS_WRITING;
    end

    if (commit) begin
      if (bs_q[commit_sel] == BS_WRITING) begin
        rows_d[commit_sel] = commit_rows;
        cols_d[commit_sel] = commit_cols;
        if (shape_ok) begin
          bs_d[commit_sel] = BS_FULL;
          q_push           = !q_full;
        end else begin
          bs_d[commit_sel] = BS_FREE;
          err_shape_d      = 1'b1;
        end
      end else begin
        err_commit_d = 1'b1;
      end
    end

    case (drn_st_q)
      D_IDLE: begin
        if (!q_empty) begin
          q_pop        = 1'b1;
          bs_d[q_head] = BS_DRAINING;
          drn_sel_d    = q_head;
          drn_rows_d   = rows_q[q_head];
          drn_cols_d   = cols_q[q_head];
          drn_st_d     = D_START;
        end
      end
      D_START: drn_st_d = D_WAIT;
      D_WAIT: begin
        if (drn_done || wd_fire) begin
          bs_d[drn_bankset_sel] = BS_FREE;
          drn_st_d              = D_IDLE;
        end
      end
      default: drn_st_d = D_IDLE;
    endcase

    for (int i = 0; i < NSETS; i++) begin
      if (bs_d[i] == BS_FREE)
        free_cnt_d = free_cnt_d + 2'd1;
    end
  end

  // last_gnt resets to 1 so the first grant with both banksets free picks 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSETS; i++) begin
        bs_q[i]   <= BS_FREE;
        rows_q[i] <= '0;
        cols_q[i] <= '0;
      end
      drn_st_q        <= D_IDLE;
      last_gnt_q      <= 1'b1;
      alloc_gnt       <= 1'b0;
      alloc_sel       <= 1'b0;
      drn_bankset_sel <= 1'b0;
      drn_tile_rows   <= '0;
      drn_tile_cols   <= '0;
      free_cnt        <= 2'd2;
      err_commit      <= 1'b0;
      err_shape       <= 1'b0;
    end else begin
      bs_q            <= bs_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      drn_st_q        <= drn_st_d;
      last_gnt_q      <= last_gnt_d;
      alloc_gnt       <= alloc_gnt_d;
      alloc_sel       <= alloc_sel_d;
      drn_bankset_sel <= drn_sel_d;
      drn_tile_rows   <= drn_rows_d;
      drn_tile_cols   <= drn_cols_d;
      free_cnt        <= free_cnt_d;
      err_commit      <= err_commit_d;
      err_shape       <= err_shape_d;
    end
  end

endmodule

// File: tb/tb_c_tile_drain_scheduler.sv
// Bench for c_tile_drain_scheduler: directed vectors, a bankset/queue model and literal checks.
// Watchdog checks are compiled in when C_SCHED_WATCHDOG_EN is defined.
module tb_c_tile_drain_scheduler;

  localparam int TB_TIMEOUT = 8;
  localparam int S_FREE = 0, S_WR = 1, S_FULL = 2, S_DRN = 3;

  logic        clk;
  logic        rst_n;
  logic        alloc_req;
  logic        alloc_gnt;
  logic        alloc_sel;
  logic        commit;
  logic        commit_sel;
  logic [15:0] commit_rows;
  logic [15:0] commit_cols;
  logic        drn_start;
  logic        drn_bankset_sel;
  logic [15:0] drn_tile_rows;
  logic [15:0] drn_tile_cols;
  logic        drn_done;
  logic [1:0]  free_cnt;
  logic        err_commit;
  logic        err_shape;
  logic        err_timeout;

  int n_checks;
  int n_fail;

  c_tile_drain_scheduler #(
    .DIM_W       (16),
    .T           (16),
    .MAX_COLS    (512),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_sel       (alloc_sel),
    .commit          (commit),
    .commit_sel      (commit_sel),
    .commit_rows     (commit_rows),
    .commit_cols     (commit_cols),
    .drn_start       (drn_start),
    .drn_bankset_sel (drn_bankset_sel),
    .drn_tile_rows   (drn_tile_rows),
    .drn_tile_cols   (drn_tile_cols),
    .drn_done        (drn_done),
    .free_cnt        (free_cnt),
    .err_commit      (err_commit),
    .err_shape       (err_shape),
    .err_timeout     (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per-bankset lifecycle, a commit-order list and the one drain in flight.
  int m_st [2];
  int m_rows [2];
  int m_cols [2];
  int m_q [$];
  bit m_gnt;
  int m_sel;
  int m_last;
  bit m_start;
  int m_active;
  int m_dsel, m_drows, m_dcols;
  int m_wait;
  bit m_err_c, m_err_s, m_err_t;
  int m_free;

  always @(posedge clk or negedge rst_n) begin
    int ns [2];
    int cs;
    bit was_start;
    if (!rst_n) begin
      m_st = '{S_FREE, S_FREE};
      m_rows = '{0, 0};
      m_cols = '{0, 0};
      m_q.delete();
      m_gnt = 0; m_sel = 0; m_last = -1; m_start = 0; m_active = -1;
      m_dsel = 0; m_drows = 0; m_dcols = 0; m_wait = 0;
      m_err_c = 0; m_err_s = 0; m_err_t = 0; m_free = 2;
    end else begin
      ns = m_st;
      if (alloc_req && !m_gnt && (m_st[0] == S_FREE || m_st[1] == S_FREE)) begin
        if (m_st[0] == S_FREE && m_st[1] == S_FREE)
          m_sel = (m_last == 0) ? 1 : 0;
        else
          m_sel = (m_st[0] == S_FREE) ? 0 : 1;
        ns[m_sel] = S_WR;
        m_last = m_sel;
        m_gnt = 1;
      end else begin
        m_gnt = 0;
      end
      was_start = m_start;
      m_start = 0;
      if (m_active < 0) begin
        if (m_q.size() > 0) begin
          m_active = m_q.pop_front();
          ns[m_active] = S_DRN;
          m_start = 1;
          m_dsel = m_active; m_drows = m_rows[m_active]; m_dcols = m_cols[m_active];
          m_wait = 0;
        end
      end else if (!was_start) begin
        if (drn_done) begin
          ns[m_active] = S_FREE;
          m_active = -1;
        end
`ifdef C_SCHED_WATCHDOG_EN
        else begin
          m_wait++;
          if (m_wait == TB_TIMEOUT) begin
            m_err_t = 1;
            ns[m_active] = S_FREE;
            m_active = -1;
          end
        end
`endif
      end
      if (commit) begin
        cs = int'(commit_sel);
        if (m_st[cs] == S_WR) begin
          if (commit_rows >= 1 && commit_rows <= 16 && commit_cols >= 1 && commit_cols <= 512) begin
            ns[cs] = S_FULL;
            m_rows[cs] = int'(commit_rows);
            m_cols[cs] = int'(commit_cols);
            m_q.push_back(cs);
          end else begin
            ns[cs] = S_FREE;
            m_err_s = 1;
          end
        end else begin
          m_err_c = 1;
        end
      end
      m_free = 0;
      for (int i = 0; i < 2; i++) if (ns[i] == S_FREE) m_free++;
      m_st = ns;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("model alloc_gnt", 32'(alloc_gnt), 32'(m_gnt));
      if (m_gnt) check_output("model alloc_sel", 32'(alloc_sel), m_sel);
      check_output("model drn_start", 32'(drn_start), 32'(m_start));
      if (m_active >= 0) begin
        check_output("model drn_bankset_sel", 32'(drn_bankset_sel), m_dsel);
        check_output("model drn_tile_rows", 32'(drn_tile_rows), m_drows);
        check_output("model drn_tile_cols", 32'(drn_tile_cols), m_dcols);
      end
      check_output("model free_cnt", 32'(free_cnt), m_free);
      check_output("model err_commit", 32'(err_commit), 32'(m_err_c));
      check_output("model err_shape", 32'(err_shape), 32'(m_err_s));
      check_output("model err_timeout", 32'(err_timeout), 32'(m_err_t));
    end
  end

  // Holds one input vector for exactly one cycle, returning on the next falling edge.
  task automatic apply_stimulus(input logic req, input logic cm, input logic sel,
                                input int rows, input int cols, input logic done);
    alloc_req   = req;
    commit      = cm;
    commit_sel  = sel;
    commit_rows = 16'(rows);
    commit_cols = 16'(cols);
    drn_done    = done;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " alloc_gnt"}, 32'(alloc_gnt), 0);
    check_output({tag, " alloc_sel"}, 32'(alloc_sel), 0);
    check_output({tag, " drn_start"}, 32'(drn_start), 0);
    check_output({tag, " drn_bankset_sel"}, 32'(drn_bankset_sel), 0);
    check_output({tag, " drn_tile_rows"}, 32'(drn_tile_rows), 0);
    check_output({tag, " drn_tile_cols"}, 32'(drn_tile_cols), 0);
    check_output({tag, " free_cnt"}, 32'(free_cnt), 2);
    check_output({tag, " err_commit"}, 32'(err_commit), 0);
    check_output({tag, " err_shape"}, 32'(err_shape), 0);
    check_output({tag, " err_timeout"}, 32'(err_timeout), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    alloc_req = 0; commit = 0; commit_sel = 0; commit_rows = 0; commit_cols = 0; drn_done = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] first grant and single drain");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("first grant", 32'(alloc_gnt), 1);
    check_output("first grant sel", 32'(alloc_sel), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("free after grant", 32'(free_cnt), 1);
    apply_stimulus(0, 1, 0, 16, 512, 0);
    check_output("no start at k+1", 32'(drn_start), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("start at k+2", 32'(drn_start), 1);
    check_output("start sel", 32'(drn_bankset_sel), 0);
    check_output("start rows", 32'(drn_tile_rows), 16);
    check_output("start cols", 32'(drn_tile_cols), 512);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("start one cycle", 32'(drn_start), 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output("free after done", 32'(free_cnt), 2);

    $display("[TB] both banksets, drains in commit order");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("alternate grant sel", 32'(alloc_sel), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("no back-to-back grant", 32'(alloc_gnt), 0);
    apply_stimulus(1, 1, 1, 4, 8, 0);
    check_output("second grant at k+3", 32'(alloc_gnt), 1);
    check_output("second grant sel", 32'(alloc_sel), 0);
    apply_stimulus(0, 1, 0, 16, 16, 0);
    check_output("first drain sel", 32'(drn_bankset_sel), 1);
    check_output("first drain rows", 32'(drn_tile_rows), 4);
    check_output("first drain cols", 32'(drn_tile_cols), 8);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    check_output("free one drained", 32'(free_cnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("back-to-back start", 32'(drn_start), 1);
    check_output("second drain sel", 32'(drn_bankset_sel), 0);
    check_output("second drain rows", 32'(drn_tile_rows), 16);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] commit and done in the same cycle");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 4, 4, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("drain 0 start", 32'(drn_start), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2, 2, 1);
    check_output("simultaneous free_cnt", 32'(free_cnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("drain 1 start", 32'(drn_start), 1);
    check_output("drain 1 sel", 32'(drn_bankset_sel), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] shape and commit errors");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("grant for bad cols", 32'(alloc_sel), 1);
    apply_stimulus(0, 1, 1, 16, 0, 0);
    check_output("err_shape cols=0", 32'(err_shape), 1);
    check_output("free after bad cols", 32'(free_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("no start after bad cols", 32'(drn_start), 0);
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("grant for bad rows", 32'(alloc_sel), 0);
    apply_stimulus(0, 1, 0, 17, 1, 0);
    check_output("free after bad rows", 32'(free_cnt), 2);
    check_output("no err_commit yet", 32'(err_commit), 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0);
      check_output("no start after bad rows", 32'(drn_start), 0);
    end
    apply_stimulus(0, 1, 1, 4, 4, 0);
    check_output("err_commit on FREE", 32'(err_commit), 1);
    check_output("free after bad commit", 32'(free_cnt), 2);

    $display("[TB] grant blocked until a drain completes");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 3, 3, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("blocked drain start", 32'(drn_start), 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check_output("no grant while full", 32'(alloc_gnt), 0);
    end
    apply_stimulus(1, 0, 0, 0, 0, 1);
    check_output("no same-cycle grant", 32'(alloc_gnt), 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("grant after done", 32'(alloc_gnt), 1);
    check_output("grant after done sel", 32'(alloc_sel), 1);
    apply_stimulus(0, 1, 0, 5, 6, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("pre-reset drain rows", 32'(drn_tile_rows), 5);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] reset during drain wait");
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("grant after mid reset", 32'(alloc_gnt), 1);
    check_output("grant sel after mid reset", 32'(alloc_sel), 0);

`ifdef C_SCHED_WATCHDOG_EN
    $display("[TB] drain watchdog");
    apply_stimulus(0, 1, 0, 2, 2, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("watchdog drain start", 32'(drn_start), 1);
    idle(8);
    check_output("no timeout yet", 32'(err_timeout), 0);
    idle(1);
    check_output("err_timeout", 32'(err_timeout), 1);
    check_output("free after timeout", 32'(free_cnt), 2);
`else
    apply_stimulus(0, 1, 0, 2, 2, 0);
    idle(4);
    check_output("timeout tied low", 32'(err_timeout), 0);
`endif
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
